// File: rtl/vec_issue_ctrl_if.sv
// Host push channel and core issue pins of the vector issue sequencer.
// The master drives instructions in; the slave (sequencer) drives the core-facing issue pins.
interface vec_issue_ctrl_if;
  logic [12:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] proc_instr;
  logic        proc_set;

  modport master (output in_instr, in_valid, input in_ready, proc_instr, proc_set);
  modport slave  (input in_instr, in_valid, output in_ready, proc_instr, proc_set);
endinterface

// File: rtl/vec_issue_ctrl.sv
// In-order single-issue vector sequencer: FIFO-buffered, issue >=1 cycle after push, spaced by opcode-class latency.
// Backpressure: in_ready drops only when the FIFO is full; pause/WAIT stall issue without dropping pushes.
module vec_issue_ctrl #(
  parameter int DEPTH   = 8,
  parameter int LD_LAT  = 1,
  parameter int ST_LAT  = 1,
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  vec_issue_ctrl_if.slave    bus,
  input  logic               pause,
  input  logic               flush,
  output logic               busy,
  output logic [15:0]        issued_cnt
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int M1   = (LD_LAT > ST_LAT) ? LD_LAT : ST_LAT;
  localparam int M2   = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int MAXL = (M1 > M2) ? M1 : M2;
  localparam int WW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] next_wait;
  state_t        state;
  logic [12:0]   head;
  logic          full, empty, push, issue;

  assign head        = mem[rd_ptr];
  assign full        = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign bus.in_ready = !full;
  // flush drops a same-cycle push as well as the queued entries
  assign push        = bus.in_valid & !full & !flush;
  // state==S_WAIT exactly when wait_cnt is non-zero
  assign issue       = !flush & !pause & !empty & (state != S_WAIT);
  assign busy        = !empty | (wait_cnt != '0);

  always_comb begin
    next_wait = '0;
    case (head[12:11])
      2'b00:   next_wait = WW'(LD_LAT - 1);
      2'b01:   next_wait = WW'(ST_LAT - 1);
      2'b10:   next_wait = WW'(ADD_LAT - 1);
      default: next_wait = WW'(MUL_LAT - 1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_instr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      wait_cnt       <= '0;
      state          <= S_IDLE;
      bus.proc_instr <= '0;
      bus.proc_set   <= 1'b0;
      issued_cnt     <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + AW'(1);
        if (issue) rd_ptr <= rd_ptr + AW'(1);
        case ({push, issue})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end

      bus.proc_set <= issue;
      if (issue) begin
        bus.proc_instr <= head;
        issued_cnt     <= issued_cnt + 16'd1;
      end

      // An op in WAIT keeps counting down even while paused
      if (flush) begin
        wait_cnt <= '0;
        state    <= pause ? S_HALT : S_IDLE;
      end else if (issue) begin
        wait_cnt <= next_wait;
        state    <= (next_wait != '0) ? S_WAIT : S_IDLE;
      end else if (wait_cnt != '0) begin
        wait_cnt <= wait_cnt - WW'(1);
        state    <= (wait_cnt == WW'(1)) ? (pause ? S_HALT : S_IDLE) : S_WAIT;
      end else begin
        state    <= pause ? S_HALT : S_IDLE;
      end
    end
  end

endmodule
